// File: rtl/queen_pkg.sv
// Shared types and constants for the 8-queen backtracking solver.
// Stack entries carry {row, col}, with the row in the upper half.
package queen_pkg;

  localparam int N       = 8;
  localparam int COORD_W = 3;
  localparam int SIZE    = 2 * COORD_W;
  localparam int COUNT_W = 7;

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    PUSH,
    PUSH_WAIT,
    POP,
    POP_WAIT,
    FOUND,
    DONE,
    ERROR
  } state_t;

  function automatic logic [SIZE-1:0] pack_entry(input logic [COORD_W-1:0] row,
                                                 input logic [COORD_W-1:0] col);
    return {row, col};
  endfunction

  function automatic logic [COORD_W-1:0] entry_row(input logic [SIZE-1:0] entry);
    return entry[SIZE-1:COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] entry_col(input logic [SIZE-1:0] entry);
    return entry[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/queen_conflict_check.sv
// Combinational attack test of a candidate (row, col) against the queens
// already placed on rows strictly above it.
module queen_conflict_check
  import queen_pkg::*;
(
  input  logic [N*COORD_W-1:0] board,
  input  logic [COORD_W-1:0]   row,
  input  logic [COORD_W-1:0]   col,
  output logic                 conflict
);

  logic [N-1:0] hit;

  for (genvar r = 0; r < N; r++) begin : g_row
    logic [COORD_W-1:0] placed;
    logic [COORD_W-1:0] row_dist;
    logic [COORD_W-1:0] col_dist;

    assign placed   = board[COORD_W*r +: COORD_W];
    assign row_dist = row - COORD_W'(r);
    assign col_dist = (col >= placed) ? (col - placed) : (placed - col);
    // Rows at or below the candidate hold stale data and are masked off.
    assign hit[r]   = (COORD_W'(r) < row) && ((placed == col) || (row_dist == col_dist));
  end

  assign conflict = |hit;

endmodule

// File: rtl/queen_solver.sv
// Backtracking controller: walks the search tree one candidate per cycle,
// pushing accepted placements onto an external stack and popping on dead ends.
module queen_solver
  import queen_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 next,
  output logic                 stk_push,
  output logic                 stk_pop,
  output logic [SIZE-1:0]      stk_bus_out,
  input  logic [SIZE-1:0]      stk_bus_in,
  input  logic                 stk_ready,
  input  logic                 stk_overflow,
  input  logic                 stk_underflow,
  output logic                 busy,
  output logic                 found,
  output logic                 done,
  output logic                 error,
  output logic [N*COORD_W-1:0] solution,
  output logic [COUNT_W-1:0]   sol_count
);

  localparam logic [COORD_W:0]   COL_END   = (COORD_W+1)'(N);
  localparam logic [COORD_W:0]   COL_ONE   = (COORD_W+1)'(1);
  localparam logic [COORD_W-1:0] ROW_LAST  = COORD_W'(N-1);
  localparam logic [COORD_W-1:0] ROW_ONE   = COORD_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  state_t              state;
  logic [COORD_W-1:0]  row;
  logic [COORD_W:0]    col;
  logic [N*COORD_W-1:0] board;
  logic                conflict;
  logic                col_end;

  assign col_end = (col == COL_END);

  queen_conflict_check u_conflict (
    .board    (board),
    .row      (row),
    .col      (col[COORD_W-1:0]),
    .conflict (conflict)
  );

  // Handshake: a push or pop is issued only in a cycle where stk_ready is
  // high, and is a single-cycle pulse; the result (flags, pop data) is taken
  // in the first later cycle where stk_ready is high again.
  assign stk_push    = (state == PUSH) && stk_ready;
  assign stk_pop     = (state == POP) && stk_ready;
  assign stk_bus_out = pack_entry(row, col[COORD_W-1:0]);

  assign found    = (state == FOUND);
  assign done     = (state == DONE);
  assign error    = (state == ERROR);
  assign busy     = !((state == IDLE) || (state == FOUND) || (state == DONE) || (state == ERROR));
  assign solution = board;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      board     <= '0;
      sol_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            row       <= '0;
            col       <= '0;
            sol_count <= '0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (col_end) begin
            state <= (row == '0) ? DONE : POP;
          end else if (conflict) begin
            col <= col + COL_ONE;
          end else begin
            state <= PUSH;
          end
        end
        PUSH: begin
          if (stk_ready) begin
            board[COORD_W*row +: COORD_W] <= col[COORD_W-1:0];
            state                         <= PUSH_WAIT;
          end
        end
        PUSH_WAIT: begin
          if (stk_ready) begin
            if (stk_overflow) begin
              state <= ERROR;
            end else if (row == ROW_LAST) begin
              state <= FOUND;
              if (sol_count != COUNT_MAX) sol_count <= sol_count + COUNT_ONE;
            end else begin
              row   <= row + ROW_ONE;
              col   <= '0;
              state <= CHECK;
            end
          end
        end
        FOUND: begin
          if (next) state <= POP;
        end
        POP: begin
          if (stk_ready) state <= POP_WAIT;
        end
        POP_WAIT: begin
          if (stk_ready) begin
            if (stk_underflow) begin
              state <= ERROR;
            end else begin
              // Resume one column past the queen that was just lifted.
              row   <= entry_row(stk_bus_in);
              col   <= {1'b0, entry_col(stk_bus_in)} + COL_ONE;
              state <= CHECK;
            end
          end
        end
        ERROR: state <= ERROR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_queen_solver.sv
// Bench for queen_solver: a behavioural LIFO stack with configurable latency,
// and a reference list of all solutions built from permutations.
module tb_queen_solver;

  localparam int BN    = 8;
  localparam int CW    = 3;
  localparam int SW    = 6;
  localparam int DEPTH = 8;
  localparam int BUDGET = 20000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic next = 1'b0;
  logic stk_push, stk_pop;
  logic [SW-1:0] stk_bus_out;
  logic [SW-1:0] stk_bus_in = '0;
  logic stk_ready = 1'b1;
  logic stk_overflow = 1'b0;
  logic stk_underflow = 1'b0;
  logic busy, found, done, error;
  logic [BN*CW-1:0] solution;
  logic [6:0] sol_count;
  logic chk_conflict;

  int tests = 0;
  int fails = 0;

  logic [BN*CW-1:0] exp_q[$];
  int exp_pushes = 0;
  int exp_first_pushes = 0;

  logic [SW-1:0] stk_q[$];
  int push_cnt = 0;
  int pop_cnt = 0;
  int viol = 0;
  int lat_lo = 0;
  int lat_hi = 0;
  bit force_uf = 1'b0;

  queen_solver dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .next          (next),
    .stk_push      (stk_push),
    .stk_pop       (stk_pop),
    .stk_bus_out   (stk_bus_out),
    .stk_bus_in    (stk_bus_in),
    .stk_ready     (stk_ready),
    .stk_overflow  (stk_overflow),
    .stk_underflow (stk_underflow),
    .busy          (busy),
    .found         (found),
    .done          (done),
    .error         (error),
    .solution      (solution),
    .sol_count     (sol_count)
  );

  queen_conflict_check chk (
    .board    (solution),
    .row      (3'd7),
    .col      (solution[BN*CW-1 -: CW]),
    .conflict (chk_conflict)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit prefix_safe(input int p[BN], input int k);
    for (int a = 0; a < k; a++)
      for (int b = a + 1; b < k; b++) begin
        int diff = p[a] - p[b];
        if (diff < 0) diff = -diff;
        if (diff == b - a) return 1'b0;
      end
    return 1'b1;
  endfunction

  function automatic logic [BN*CW-1:0] pack_board(input int p[BN]);
    logic [BN*CW-1:0] v = '0;
    for (int r = 0; r < BN; r++) v[CW*r +: CW] = CW'(p[r]);
    return v;
  endfunction

  // Permutations in lexicographic order visit prefixes exactly in depth-first
  // order; every safe prefix is one accepted placement.
  task automatic build_reference();
    int p[BN];
    int d;
    int i;
    int j;
    int t;
    int lo;
    int hi;
    bit more;
    for (int n = 0; n < BN; n++) p[n] = n;
    d = 0;
    more = 1'b1;
    while (more) begin
      for (int k = d + 1; k <= BN; k++) begin
        if (prefix_safe(p, k)) begin
          exp_pushes++;
          if (k == BN) begin
            if (exp_q.size() == 0) exp_first_pushes = exp_pushes;
            exp_q.push_back(pack_board(p));
          end
        end
      end
      i = BN - 2;
      while (i >= 0 && p[i] > p[i+1]) i--;
      if (i < 0) begin
        more = 1'b0;
      end else begin
        j = BN - 1;
        while (p[j] < p[i]) j--;
        t = p[i]; p[i] = p[j]; p[j] = t;
        lo = i + 1;
        hi = BN - 1;
        while (lo < hi) begin
          t = p[lo]; p[lo] = p[hi]; p[hi] = t;
          lo++; hi--;
        end
        d = i;
      end
    end
  endtask

  // ---------------- stack model ----------------
  initial begin
    int hold;
    logic [SW-1:0] ndata;
    bit nov;
    bit nun;
    hold = 0; ndata = '0; nov = 1'b0; nun = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stk_q.delete();
        hold = 0; ndata = '0; nov = 1'b0; nun = 1'b0;
      end else begin
        if (stk_push && stk_pop) viol++;
        if ((stk_push || stk_pop) && !stk_ready) viol++;
        if (stk_push && stk_ready) begin
          push_cnt++;
          if (stk_q.size() >= DEPTH) nov = 1'b1;
          else begin nov = 1'b0; stk_q.push_back(stk_bus_out); end
          nun = 1'b0;
          hold = $urandom_range(lat_hi, lat_lo);
        end else if (stk_pop && stk_ready) begin
          pop_cnt++;
          if (force_uf || stk_q.size() == 0) nun = 1'b1;
          else begin nun = 1'b0; ndata = stk_q.pop_back(); end
          nov = 1'b0;
          hold = $urandom_range(lat_hi, lat_lo);
        end else if (hold > 0) begin
          hold--;
        end
      end
      @(posedge clk);
      #1;
      stk_ready = (hold == 0);
      stk_bus_in = ndata;
      stk_overflow = nov;
      stk_underflow = nun;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_next();
    next = 1'b1;
    tick();
    next = 1'b0;
  endtask

  task automatic wait_event(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(found || done || error) && n < BUDGET);
    if (!(found || done || error)) check({tag, "_timeout"}, {29'd0, found, done, error}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_found"}, found, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_push"}, stk_push, 0);
    check({tag, "_pop"}, stk_pop, 0);
    check({tag, "_bus_out"}, stk_bus_out, 0);
    check({tag, "_solution"}, solution, 0);
    check({tag, "_count"}, sol_count, 0);
  endtask

  task automatic check_solution(input string tag, input int idx);
    logic [BN*CW-1:0] e;
    e = (idx < exp_q.size()) ? exp_q[idx] : '1;
    check({tag, "_found"}, found, 1);
    check({tag, "_solution"}, solution, e);
    check({tag, "_count"}, sol_count, idx + 1);
    check({tag, "_no_attack"}, chk_conflict, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int bp;
    int bq;
    int nsol;
    int extra;
    int target;
    int n;

    build_reference();

    reset = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // Zero-latency stack: first solution, start ignored in FOUND, full sweep.
    lat_lo = 0; lat_hi = 0;
    bp = push_cnt; bq = pop_cnt;
    pulse_start();
    wait_event("first");
    check_solution("first", 0);
    check("first_busy", busy, 0);
    check("first_depth", stk_q.size(), DEPTH);
    check("first_pushes", push_cnt - bp, exp_first_pushes);

    pulse_start();
    repeat (4) @(negedge clk);
    check_solution("start_in_found", 0);

    nsol = 1;
    while (found && nsol < 200) begin
      pulse_next();
      wait_event("resume");
      if (found) begin
        check_solution("sweep", nsol);
        nsol++;
      end
    end
    check("sweep_done", done, 1);
    check("sweep_n_found", nsol, exp_q.size());
    check("sweep_count", sol_count, exp_q.size());
    check("sweep_stack_empty", stk_q.size(), 0);
    check("sweep_pushes", push_cnt - bp, exp_pushes);
    check("sweep_pops", pop_cnt - bq, exp_pushes);
    bp = push_cnt; bq = pop_cnt;
    repeat (20) @(negedge clk);
    check("idle_no_push", push_cnt, bp);
    check("idle_no_pop", pop_cnt, bq);
    check("idle_done", done, 1);

    // Restart from DONE under random stack latency.
    lat_lo = 0; lat_hi = 3;
    pulse_start();
    wait_event("rand_first");
    check_solution("rand_first", 0);
    extra = $urandom_range(5, 2);
    for (int i = 1; i <= extra; i++) begin
      pulse_next();
      wait_event("rand_next");
      check_solution("rand_next", i);
    end

    // Fixed three-cycle stall after every stack operation.
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    lat_lo = 3; lat_hi = 3;
    bp = push_cnt; bq = pop_cnt;
    pulse_start();
    wait_event("slow_first");
    check_solution("slow_first", 0);
    check("slow_pushes", push_cnt - bp, exp_first_pushes);
    check("slow_net_depth", (push_cnt - bp) - (pop_cnt - bq), DEPTH);

    // Underflow on the first pop after next is fatal until reset.
    force_uf = 1'b1;
    pulse_next();
    wait_event("underflow");
    check("uf_error", error, 1);
    check("uf_busy", busy, 0);
    check("uf_found", found, 0);
    bp = push_cnt; bq = pop_cnt;
    pulse_next();
    pulse_start();
    repeat (6) @(negedge clk);
    check("uf_sticky_error", error, 1);
    check("uf_sticky_busy", busy, 0);
    check("uf_sticky_push", push_cnt, bp);
    check("uf_sticky_pop", pop_cnt, bq);
    force_uf = 1'b0;

    // Reset asserted while a push is being acknowledged.
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    target = push_cnt + $urandom_range(40, 3);
    pulse_start();
    n = 0;
    while (push_cnt < target && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reached", push_cnt >= target, 1);
    tick();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrst");
    reset = 1'b1;
    pulse_start();
    wait_event("midrst_first");
    check_solution("midrst_first", 0);
    check("protocol_violations", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
